// File: rtl/currctrl_debug_pkg.sv
// Shared types and sizing for the CurrCTRL debug capture block.
package currctrl_debug_pkg;

  localparam int DBG_ADDR_W = 9;
  localparam int DBG_DEPTH  = 512;
  localparam int DBG_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRETRIG = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } dbg_state_e;

  function automatic logic is_capturing(dbg_state_e s);
    return (s == PRETRIG) || (s == ARMED) || (s == POST);
  endfunction

endpackage

// File: rtl/currctrl_debug_capture_if.sv
// Write-only bus from the capture logic into port 2 of the CurrCTRL debug RAM.
interface currctrl_debug_capture_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_writedata;
  logic [3:0]        ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;

  modport master (
    output ram_address, ram_writedata, ram_byteenable, ram_chipselect, ram_write
  );

  modport slave (
    input ram_address, ram_writedata, ram_byteenable, ram_chipselect, ram_write
  );
endinterface

// File: rtl/currctrl_dbg_trig_detect.sv
// Signed level-crossing detector; trig is combinational and aligned with the strobe.
module currctrl_dbg_trig_detect #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     strobe,
  input  logic signed [DATA_W-1:0] data,
  input  logic signed [DATA_W-1:0] level,
  input  logic                     falling,
  output logic                     trig
);

  logic signed [DATA_W-1:0] prev_data;
  logic                     prev_vld;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev_vld <= 1'b0;
    end else if (strobe) begin
      prev_vld <= 1'b1;
    end
  end

  // NOTE: prev_data carries no reset; it is only ever used qualified by prev_vld.
  always_ff @(posedge clk) begin
    if (strobe) prev_data <= data;
  end

  assign trig = strobe && prev_vld &&
                (falling ? ((prev_data >= level) && (data <  level))
                         : ((prev_data <  level) && (data >= level)));

endmodule

// File: rtl/currctrl_debug_capture.sv
// Trigger-based sample logger writing a circular pre/post-trigger record into the debug RAM.
// Optional decimation is enabled by defining CURRCTRL_DBG_DECIM_EN.
module currctrl_debug_capture
  import currctrl_debug_pkg::*;
#(
  parameter int ADDR_W  = DBG_ADDR_W,
  parameter int DATA_W  = DBG_DATA_W,
  parameter int DECIM_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_data,
  input  logic                     arm,
  input  logic                     abort,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic                     trig_falling,
  input  logic [ADDR_W-1:0]        pretrig_count,
`ifdef CURRCTRL_DBG_DECIM_EN
  input  logic [DECIM_W-1:0]       decim,
`endif
  currctrl_debug_capture_if.master ram,
  output logic                     busy,
  output logic                     triggered,
  output logic                     done,
  output logic [ADDR_W-1:0]        trig_index,
  output logic [ADDR_W-1:0]        start_index
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_MAX   = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dbg_state_e        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre;
  logic [ADDR_W-1:0] cnt;        // pre-trigger count up, then post-trigger count down
  logic [ADDR_W-1:0] pre_next;
  logic              capturing;
  logic              dec_tick;
  logic              accept;
  logic              arm_ok;
  logic              trig;

  assign capturing = is_capturing(state);
  assign busy      = capturing;
  assign pre_next  = (pretrig_count > PRE_MAX) ? PRE_MAX : pretrig_count;
  assign arm_ok    = arm && !abort && !capturing;

`ifdef CURRCTRL_DBG_DECIM_EN
  logic [DECIM_W-1:0] dec_cnt;

  always_ff @(posedge clk) begin
    if (reset || arm_ok) begin
      dec_cnt <= '0;
    end else if (sample_valid && capturing) begin
      dec_cnt <= (dec_cnt == decim) ? '0 : dec_cnt + DECIM_W'(1);
    end
  end

  assign dec_tick = (dec_cnt == '0);
`else
  assign dec_tick = 1'b1;
`endif

  // A sample offered alongside abort is dropped rather than written.
  assign accept = sample_valid && capturing && dec_tick && !abort;

  currctrl_dbg_trig_detect #(.DATA_W(DATA_W)) u_trig (
    .clk     (clk),
    .reset   (reset),
    .clear   (arm_ok),
    .strobe  (accept),
    .data    (sample_data),
    .level   (trig_level),
    .falling (trig_falling),
    .trig    (trig)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      pre         <= '0;
      cnt         <= '0;
      triggered   <= 1'b0;
      done        <= 1'b0;
      trig_index  <= '0;
      start_index <= '0;
    end else if (abort) begin
      state     <= IDLE;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else if (arm_ok) begin
      state     <= (pre_next == '0) ? ARMED : PRETRIG;
      wr_ptr    <= '0;
      pre       <= pre_next;
      cnt       <= '0;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      case (state)
        PRETRIG: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt + ADDR_W'(1) == pre) state <= ARMED;
        end
        ARMED: begin
          if (trig) begin
            trig_index <= wr_ptr;
            triggered  <= 1'b1;
            cnt        <= LAST_ADDR - pre;
            state      <= POST;
          end
        end
        POST: begin
          cnt <= cnt - ADDR_W'(1);
          if (cnt == ADDR_W'(1)) begin
            state       <= DONE;
            done        <= 1'b1;
            start_index <= trig_index - pre;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram.ram_write     <= 1'b0;
      ram.ram_address   <= '0;
      ram.ram_writedata <= '0;
    end else begin
      ram.ram_write <= accept;
      if (accept) begin
        ram.ram_address   <= wr_ptr;
        ram.ram_writedata <= sample_data;
      end
    end
  end

  assign ram.ram_byteenable = 4'hF;
  assign ram.ram_chipselect = ram.ram_write;

endmodule
